// File: rtl/store_access_sequencer_pkg.sv
// Shared store-lane definitions: opcodes, width encodings, base byte masks and sequencer states.
package store_access_sequencer_pkg;

   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;

   localparam logic [2:0] FNC_SB = 3'b000;
   localparam logic [2:0] FNC_SH = 3'b001;
   localparam logic [2:0] FNC_SW = 3'b010;

   localparam logic [3:0] MASK_SB = 4'b0001;
   localparam logic [3:0] MASK_SH = 4'b0011;
   localparam logic [3:0] MASK_SW = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } state_e;

endpackage

// File: rtl/store_access_sequencer_if.sv
// Request handshake from the execute stage and beat interface to the byte-writable data memory.
interface store_access_sequencer_if #(
   parameter int ADDR_W = 14
) ();
   logic              req_valid;
   logic              req_ready;
   logic [6:0]        req_opcode;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_data;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_we;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic              done;
   logic              misaligned_err;

   modport slave (
      input  req_valid, req_opcode, req_funct3, req_addr, req_data, mem_ack,
      output req_ready, mem_en, mem_addr, mem_we, mem_wdata, done, misaligned_err
   );

   modport master (
      output req_valid, req_opcode, req_funct3, req_addr, req_data, mem_ack,
      input  req_ready, mem_en, mem_addr, mem_we, mem_wdata, done, misaligned_err
   );
endinterface

// File: rtl/store_access_sequencer_lane_align.sv
// Combinational byte-lane alignment: width mask shifted by byte offset, and data split
// across the current word (beat0) and the following word (beat1).
module store_lane_align
   import store_access_sequencer_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] data,
   output logic [7:0]  m8,
   output logic [31:0] b0_data,
   output logic [31:0] b1_data,
   output logic        width_ok
);
   logic [3:0]  base;
   logic [63:0] wide;

   always_comb begin
      base     = 4'b0000;
      width_ok = 1'b1;
      case (funct3)
         FNC_SB:  base = MASK_SB;
         FNC_SH:  base = MASK_SH;
         FNC_SW:  base = MASK_SW;
         default: width_ok = 1'b0;
      endcase
      m8   = {4'b0000, base} << off;
      // one 64-bit shift yields both beats' data; upper half is what spills into the next word
      wide = {32'h0000_0000, data} << {off, 3'b000};
   end

   assign b0_data = wide[31:0];
   assign b1_data = wide[63:32];

endmodule

// File: rtl/store_access_sequencer.sv
// Store sequencer: accepts one store at a time, issues one or two registered memory beats,
// and pulses done when the last beat is acknowledged.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | req_ready high; decode and accept a request
//   ST_BEAT0 | first word beat on the memory port, waiting for mem_ack
//   ST_BEAT1 | spill-over beat into the next word, waiting for mem_ack
module store_access_sequencer
   import store_access_sequencer_pkg::*;
#(
   parameter int ADDR_W           = 14,
   parameter int ALLOW_MISALIGNED = 1
) (
   input logic                      clk,
   input logic                      rst_n,
   store_access_sequencer_if.slave  bus
);
   state_e            state_q, state_d;
   logic              mem_en_q, mem_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_we_q, mem_we_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [3:0]        b1_we_q, b1_we_d;
   logic [31:0]       b1_wdata_q, b1_wdata_d;
   logic              need_b1_q, need_b1_d;

   logic [7:0]  m8;
   logic [31:0] b0_data, b1_data;
   logic        width_ok;
   logic        is_store, split;

   store_lane_align u_align (
      .funct3   (bus.req_funct3),
      .off      (bus.req_addr[1:0]),
      .data     (bus.req_data),
      .m8       (m8),
      .b0_data  (b0_data),
      .b1_data  (b1_data),
      .width_ok (width_ok)
   );

   assign is_store = (bus.req_opcode == OPC_STORE);
   assign split    = (m8[7:4] != 4'b0000);

   always_comb begin
      state_d     = state_q;
      mem_en_d    = mem_en_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      b1_we_d     = b1_we_q;
      b1_wdata_d  = b1_wdata_q;
      need_b1_d   = need_b1_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (!is_store || !width_ok) begin
                  done_d = 1'b1;
               end else if (split && (ALLOW_MISALIGNED == 0)) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  // beat1 payload is captured now so req_* may change during beat0
                  state_d     = ST_BEAT0;
                  mem_en_d    = 1'b1;
                  mem_addr_d  = bus.req_addr[ADDR_W+1:2];
                  mem_we_d    = m8[3:0];
                  mem_wdata_d = b0_data;
                  b1_we_d     = m8[7:4];
                  b1_wdata_d  = b1_data;
                  need_b1_d   = split;
               end
            end
         end
         ST_BEAT0: begin
            if (bus.mem_ack) begin
               if (need_b1_q) begin
                  state_d     = ST_BEAT1;
                  mem_addr_d  = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                  mem_we_d    = b1_we_q;
                  mem_wdata_d = b1_wdata_q;
               end else begin
                  state_d     = ST_IDLE;
                  mem_en_d    = 1'b0;
                  mem_we_d    = 4'b0000;
                  mem_wdata_d = 32'h0000_0000;
                  done_d      = 1'b1;
               end
            end
         end
         ST_BEAT1: begin
            if (bus.mem_ack) begin
               state_d     = ST_IDLE;
               mem_en_d    = 1'b0;
               mem_we_d    = 4'b0000;
               mem_wdata_d = 32'h0000_0000;
               done_d      = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 4'b0000;
         mem_wdata_q <= 32'h0000_0000;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         b1_we_q     <= 4'b0000;
         b1_wdata_q  <= 32'h0000_0000;
         need_b1_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_en_q    <= mem_en_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         b1_we_q     <= b1_we_d;
         b1_wdata_q  <= b1_wdata_d;
         need_b1_q   <= need_b1_d;
      end
   end

   assign bus.req_ready      = (state_q == ST_IDLE);
   assign bus.mem_en         = mem_en_q;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_wdata      = mem_wdata_q;
   assign bus.done           = done_q;
   assign bus.misaligned_err = err_q;

endmodule
